ball_renderer: RTL and testbench
================================

// Module: ball_renderer
// PURPOSE
//  Consumer side of the ball position path: accepts each new ball (X,Y) from the
//  ball update/collision logic and drives the 160x120 VGA adapter pixel-write port.
//  Per accepted position: erases the previous square with BG_COLOUR, then draws the
//  new BALL_SIZE x BALL_SIZE square with BALL_COLOUR, one pixel per clock.
// PARAMETERS
//  BALL_SIZE   4       square edge in pixels (1..8)
//  SCREEN_W    160     pixels with x >= SCREEN_W are not plotted
//  SCREEN_H    120     pixels with y >= SCREEN_H are not plotted
//  BALL_COLOUR 3'b111  draw colour
//  BG_COLOUR   3'b000  erase colour
// PORTS
//  clk         in   1  system clock, all state on posedge
//  resetn      in   1  asynchronous, active-low reset
//  pos_x       in   8  new ball X (top-left corner)
//  pos_y       in   7  new ball Y (top-left corner)
//  pos_valid   in   1  producer holds pos_x/pos_y stable while high
//  pos_ready   out  1  high only in IDLE; transfer when pos_valid && pos_ready
//  vga_x       out  8  pixel X to adapter
//  vga_y       out  7  pixel Y to adapter
//  vga_colour  out  3  pixel colour
//  vga_plot    out  1  write strobe, one pixel per cycle
//  draw_done   out  1  one-cycle pulse after last draw pixel
// BEHAVIOUR
//  Reset: state=IDLE, has_old=0, old_x/old_y=0, vga_x/vga_y/vga_colour/vga_plot=0,
//   draw_done=0; pos_ready reads 1 (decoded from IDLE).
//  FSM IDLE -> ERASE (if has_old) or DRAW (if !has_old) on transfer; ERASE -> DRAW
//   after BALL_SIZE^2 cycles; DRAW -> IDLE after BALL_SIZE^2 cycles.
//  Transfer in cycle N: pos_x/pos_y latched into new_x/new_y; first pixel on
//   vga_* in cycle N+1. Busy 2*BALL_SIZE^2 cycles (BALL_SIZE^2 when !has_old).
//  Scan order row-major: cx inner 0..BALL_SIZE-1, cy outer; counters reset to 0
//   on every phase entry.
//  ERASE uses old_x/old_y + BG_COLOUR; DRAW uses new_x/new_y + BALL_COLOUR.
//  Pixel address computed 9 bits wide (x) / 8 bits wide (y), no wrap; if sum
//   >= SCREEN_W / SCREEN_H, vga_plot=0 that cycle but counters still advance
//   (phase length constant).
//  Last DRAW cycle: old <= new, has_old <= 1; next cycle IDLE, vga_plot=0,
//   draw_done=1 for exactly one cycle.
//  vga_plot is 0 in IDLE; vga_x/vga_y/vga_colour hold last value.
//  pos_valid while busy: ignored, no latch; producer holds until pos_ready.
//  Reset mid-operation: immediate return to reset values; next transfer draws
//   with no erase.
// CONFIGURATION
//  BALL_RENDERER_FRAME_SYNC_EN defined: extra input port frame_tick (1 bit, one-
//   cycle pulse per video frame). Tick sets pending flag (also while busy);
//   pos_ready = IDLE && pending; pending cleared on transfer; tick coinciding
//   with transfer leaves pending set. Reset clears pending.
//  Not defined: port absent; pos_ready = IDLE.
// TESTING
//  T1 reset, pos (10,20) valid -> 16 plots x 10..13, y 20..23 colour 7, no erase,
//   draw_done pulse, pos_ready high again after 17 cycles.
//  T2 then pos (11,21) -> 16 plots colour 0 at 10..13/20..23, then 16 plots colour
//   7 at 11..14/21..24, 32 busy cycles.
//  T3 pos (158,118) -> only (158..159,118..119) plotted (4 strobes), phase still
//   16 cycles; no wrapped addresses.
//  T4 pos_valid held across busy with changing pos_x -> only one transfer,
//   taken in IDLE with value present then.
//  T5 resetn low mid-DRAW -> vga_plot 0 same cycle; next pos (5,5) draws 16
//   pixels, no erase.
//  T6 FRAME_SYNC_EN: pos_valid high, no tick -> pos_ready 0; tick -> transfer
//   next cycle; second position waits for next tick.

Source files
------------

// File: rtl/ball_renderer.sv
// ----------------------------------------------------------------------------
// ball_renderer
//
// Purpose:
//   Accepts each new ball position (top-left corner) from the ball update logic
//   and drives the 160x120 VGA adapter pixel-write port. For each accepted
//   position it first erases the previously drawn square with BG_COLOUR, and
//   then draws the new BALL_SIZE x BALL_SIZE square with BALL_COLOUR. It writes
//   one pixel per clock. The first position after reset is drawn without an
//   erase phase.
//
// Optional feature (macro BALL_RENDERER_FRAME_SYNC_EN):
//   When this macro is defined, the frame_tick input exists. A tick sets a
//   pending flag, and a position is accepted only in IDLE while the flag is
//   set, so the renderer moves the ball at most once per video frame.
//   When the macro is undefined, the port is absent and pos_ready = IDLE.
//
// Ports:
//   clk         in   1  system clock, all state on posedge
//   resetn      in   1  asynchronous active-low reset
//   frame_tick  in   1  one-cycle pulse per frame (only with the macro)
//   pos_x       in   8  new ball X (top-left corner)
//   pos_y       in   7  new ball Y (top-left corner)
//   pos_valid   in   1  producer holds pos_x/pos_y stable while high
//   pos_ready   out  1  renderer can accept a position this cycle
//   vga_x       out  8  pixel X to adapter
//   vga_y       out  7  pixel Y to adapter
//   vga_colour  out  3  pixel colour
//   vga_plot    out  1  pixel write strobe
//   draw_done   out  1  one-cycle pulse after the last draw pixel
// ----------------------------------------------------------------------------
module ball_renderer #(
  parameter int         BALL_SIZE   = 4,
  parameter int         SCREEN_W    = 160,
  parameter int         SCREEN_H    = 120,
  parameter logic [2:0] BALL_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR   = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
`ifdef BALL_RENDERER_FRAME_SYNC_EN
  input  logic       frame_tick,
`endif
  input  logic [7:0] pos_x,
  input  logic [6:0] pos_y,
  input  logic       pos_valid,
  output logic       pos_ready,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       draw_done
);

  typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW} state_t;

  localparam int            CW   = 4;
  localparam logic [CW-1:0] LAST = CW'(BALL_SIZE - 1);
  localparam logic [8:0]    SW   = 9'(SCREEN_W);
  localparam logic [7:0]    SH   = 8'(SCREEN_H);

  state_t        state_reg, state_next;
  logic [CW-1:0] cx_reg, cx_next, cy_reg, cy_next;
  logic [7:0]    new_x_reg, new_x_next, old_x_reg, old_x_next;
  logic [6:0]    new_y_reg, new_y_next, old_y_reg, old_y_next;
  logic          has_old_reg, has_old_next;
  logic [7:0]    vga_x_reg, vga_x_next;
  logic [6:0]    vga_y_reg, vga_y_next;
  logic [2:0]    vga_colour_reg, vga_colour_next;
  logic          vga_plot_reg, vga_plot_next;
  logic          done_reg, done_next;

  logic          xfer;
  logic          last_pix;
  logic [7:0]    base_x;
  logic [6:0]    base_y;
  logic [2:0]    base_colour;
  logic [8:0]    x_sum;
  logic [7:0]    y_sum;

`ifdef BALL_RENDERER_FRAME_SYNC_EN
  logic pending_reg;

  // A tick wins over the clear, so a tick that arrives in the same cycle as a
  // transfer stays pending for the next position.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      pending_reg <= 1'b0;
    else if (frame_tick)
      pending_reg <= 1'b1;
    else if (xfer)
      pending_reg <= 1'b0;
  end

  assign pos_ready = (state_reg == S_IDLE) && pending_reg;
`else
  assign pos_ready = (state_reg == S_IDLE);
`endif

  assign xfer = pos_valid && pos_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= S_IDLE;
      cx_reg         <= '0;
      cy_reg         <= '0;
      new_x_reg      <= '0;
      new_y_reg      <= '0;
      old_x_reg      <= '0;
      old_y_reg      <= '0;
      has_old_reg    <= 1'b0;
      vga_x_reg      <= '0;
      vga_y_reg      <= '0;
      vga_colour_reg <= '0;
      vga_plot_reg   <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cx_reg         <= cx_next;
      cy_reg         <= cy_next;
      new_x_reg      <= new_x_next;
      new_y_reg      <= new_y_next;
      old_x_reg      <= old_x_next;
      old_y_reg      <= old_y_next;
      has_old_reg    <= has_old_next;
      vga_x_reg      <= vga_x_next;
      vga_y_reg      <= vga_y_next;
      vga_colour_reg <= vga_colour_next;
      vga_plot_reg   <= vga_plot_next;
      done_reg       <= done_next;
    end
  end

  // cx/cy give the pixel that is on the vga_* registers in the current cycle.
  // The pixel registers are loaded from the *next* state and counters, so the
  // first pixel of a phase is already visible in the cycle after it is entered.
  always_comb begin
    state_next      = state_reg;
    cx_next         = cx_reg;
    cy_next         = cy_reg;
    new_x_next      = new_x_reg;
    new_y_next      = new_y_reg;
    old_x_next      = old_x_reg;
    old_y_next      = old_y_reg;
    has_old_next    = has_old_reg;
    done_next       = 1'b0;
    last_pix        = (cx_reg == LAST) && (cy_reg == LAST);
    base_x          = new_x_reg;
    base_y          = new_y_reg;
    base_colour     = BALL_COLOUR;
    x_sum           = '0;
    y_sum           = '0;
    vga_x_next      = vga_x_reg;
    vga_y_next      = vga_y_reg;
    vga_colour_next = vga_colour_reg;
    vga_plot_next   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (xfer) begin
          new_x_next = pos_x;
          new_y_next = pos_y;
          cx_next    = '0;
          cy_next    = '0;
          state_next = has_old_reg ? S_ERASE : S_DRAW;
        end
      end
      S_ERASE, S_DRAW: begin
        if (last_pix) begin
          cx_next = '0;
          cy_next = '0;
          if (state_reg == S_ERASE) begin
            state_next = S_DRAW;
          end else begin
            state_next   = S_IDLE;
            old_x_next   = new_x_reg;
            old_y_next   = new_y_reg;
            has_old_next = 1'b1;
            done_next    = 1'b1;
          end
        end else if (cx_reg == LAST) begin
          cx_next = '0;
          cy_next = cy_reg + 1'b1;
        end else begin
          cx_next = cx_reg + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (state_next == S_ERASE) begin
      base_x      = old_x_reg;
      base_y      = old_y_reg;
      base_colour = BG_COLOUR;
    end else begin
      base_x      = new_x_next;
      base_y      = new_y_next;
      base_colour = BALL_COLOUR;
    end

    // The sums are one bit wider than the screen coordinates, so an address
    // that goes off screen is suppressed instead of wrapping to the far edge.
    x_sum = {1'b0, base_x} + {5'd0, cx_next};
    y_sum = {1'b0, base_y} + {4'd0, cy_next};

    if (state_next != S_IDLE) begin
      vga_x_next      = x_sum[7:0];
      vga_y_next      = y_sum[6:0];
      vga_colour_next = base_colour;
      vga_plot_next   = (x_sum < SW) && (y_sum < SH);
    end
  end

  assign vga_x      = vga_x_reg;
  assign vga_y      = vga_y_reg;
  assign vga_colour = vga_colour_reg;
  assign vga_plot   = vga_plot_reg;
  assign draw_done  = done_reg;

endmodule

// File: tb/tb_ball_renderer.sv
module tb_ball_renderer;

  logic       clk;
  logic       resetn;
  logic [7:0] pos_x;
  logic [6:0] pos_y;
  logic       pos_valid;
  logic       pos_ready;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       draw_done;
`ifdef BALL_RENDERER_FRAME_SYNC_EN
  logic       frame_tick;
  localparam bit FS = 1'b1;
`else
  localparam bit FS = 1'b0;
`endif

  ball_renderer dut (
    .clk        (clk),
    .resetn     (resetn),
`ifdef BALL_RENDERER_FRAME_SYNC_EN
    .frame_tick (frame_tick),
`endif
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .pos_valid  (pos_valid),
    .pos_ready  (pos_ready),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .draw_done  (draw_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int plot_cnt;

  // Bench-side model of the last square drawn.
  bit         m_has_old;
  logic [7:0] m_ox;
  logic [6:0] m_oy;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    bit         hold;       // keep pos_valid high and jitter pos while busy
    int         exp_plots;  // hand-computed strobe count (erase + draw)
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Called at a negedge. It offers a position and waits (bounded) for it to be
  // accepted. It returns #1 after the transfer edge.
  task automatic issue(input logic [7:0] px, input logic [6:0] py, input bit hold,
                       output bit ok);
    int w;
    pos_x = px;
    pos_y = py;
    pos_valid = 1'b1;
`ifdef BALL_RENDERER_FRAME_SYNC_EN
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
`endif
    w = 0;
    while (!pos_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    ok = pos_ready;
    if (!ok) begin
      chk("ready_timeout", {31'd0, pos_ready}, 32'd1);
    end else begin
      @(posedge clk);
      #1;
      if (!hold) pos_valid = 1'b0;
    end
  endtask

  task automatic check_phase(input logic [7:0] bx, input logic [6:0] by,
                             input logic [2:0] col, input bit jitter);
    int ex, ey;
    bit inb;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      ex = int'(bx) + (k % 4);
      ey = int'(by) + (k / 4);
      inb = (ex < 160) && (ey < 120);
      chk("plot", {31'd0, vga_plot}, {31'd0, inb});
      if (vga_plot) plot_cnt++;
      if (inb) begin
        chk("vga_x", {24'd0, vga_x}, ex);
        chk("vga_y", {25'd0, vga_y}, ey);
        chk("colour", {29'd0, vga_colour}, {29'd0, col});
      end
      chk("busy_ready", {31'd0, pos_ready}, 32'd0);
      chk("busy_done", {31'd0, draw_done}, 32'd0);
      if (jitter) begin
        pos_x = 8'(k * 13 + 3);
        pos_y = 7'(k * 5 + 1);
      end
    end
  endtask

  // Called at a negedge while idle. Returns at the negedge of the idle cycle
  // that shows the draw_done pulse.
  task automatic run_xfer(input int idx, input vec_t v);
    bit ok;
    bit erased;
    issue(v.x, v.y, v.hold, ok);
    if (!ok) return;
    plot_cnt = 0;
    erased = m_has_old;
    if (m_has_old) check_phase(m_ox, m_oy, 3'b000, v.hold);
    check_phase(v.x, v.y, 3'b111, v.hold);
    @(negedge clk);
    chk("idle_plot", {31'd0, vga_plot}, 32'd0);
    chk("done_pulse", {31'd0, draw_done}, 32'd1);
    chk("idle_ready", {31'd0, pos_ready}, FS ? 32'd0 : 32'd1);
    chk("strobes", plot_cnt, v.exp_plots);
    m_has_old = 1'b1;
    m_ox = v.x;
    m_oy = v.y;
    $display("xfer %0d: pos=(%0d,%0d) erase=%0d strobes=%0d expected=%0d errors=%0d",
             idx, v.x, v.y, erased, plot_cnt, v.exp_plots, errors);
  endtask

  initial begin
    bit ok;
    vecs[0] = '{x: 8'd10,  y: 7'd20,  hold: 1'b0, exp_plots: 16};  // first: no erase
    vecs[1] = '{x: 8'd11,  y: 7'd21,  hold: 1'b0, exp_plots: 32};  // erase + draw
    vecs[2] = '{x: 8'd158, y: 7'd118, hold: 1'b0, exp_plots: 20};  // corner clip
    vecs[3] = '{x: 8'd30,  y: 7'd40,  hold: 1'b1, exp_plots: 20};  // valid held
    vecs[4] = '{x: 8'd60,  y: 7'd50,  hold: 1'b0, exp_plots: 32};
    vecs[5] = '{x: 8'd0,   y: 7'd0,   hold: 1'b0, exp_plots: 32};
    vecs[6] = '{x: 8'd159, y: 7'd10,  hold: 1'b0, exp_plots: 20};  // 1 column visible

    resetn = 1'b0;
    pos_valid = 1'b0;
    pos_x = '0;
    pos_y = '0;
`ifdef BALL_RENDERER_FRAME_SYNC_EN
    frame_tick = 1'b0;
`endif
    m_has_old = 1'b0;
    m_ox = '0;
    m_oy = '0;
    repeat (3) @(negedge clk);
    chk("rst_plot", {31'd0, vga_plot}, 32'd0);
    chk("rst_x", {24'd0, vga_x}, 32'd0);
    chk("rst_y", {25'd0, vga_y}, 32'd0);
    chk("rst_colour", {29'd0, vga_colour}, 32'd0);
    chk("rst_done", {31'd0, draw_done}, 32'd0);
    chk("rst_ready", {31'd0, pos_ready}, FS ? 32'd0 : 32'd1);
    resetn = 1'b1;
    $display("reset: plot=%0d ready=%0d errors=%0d", vga_plot, pos_ready, errors);

`ifdef BALL_RENDERER_FRAME_SYNC_EN
    // Without a tick nothing may be accepted.
    pos_x = 8'd10;
    pos_y = 7'd20;
    pos_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fs_no_tick_ready", {31'd0, pos_ready}, 32'd0);
      chk("fs_no_tick_plot", {31'd0, vga_plot}, 32'd0);
    end
    $display("frame sync: no transfer without tick, errors=%0d", errors);
`endif

    for (int i = 0; i < 7; i++) run_xfer(i, vecs[i]);

    // The draw_done pulse lasts one cycle.
    @(negedge clk);
    chk("done_one_cycle", {31'd0, draw_done}, 32'd0);

    // Assert reset in the middle of DRAW. Then expect a fresh draw with no erase.
    issue(8'd70, 8'd70, 1'b0, ok);
    repeat (21) @(negedge clk);
    chk("mid_plot", {31'd0, vga_plot}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_plot", {31'd0, vga_plot}, 32'd0);
    chk("async_rst_x", {24'd0, vga_x}, 32'd0);
    chk("async_rst_ready", {31'd0, pos_ready}, FS ? 32'd0 : 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    m_has_old = 1'b0;
    $display("mid-draw reset: plot=%0d errors=%0d", vga_plot, errors);
    run_xfer(7, '{x: 8'd5, y: 7'd5, hold: 1'b0, exp_plots: 16});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
